// File: rtl/dm_arb_pkg.sv
// Shared types and defaults for the two-port data-memory arbiter.
package dm_arb_pkg;

  localparam int AW_DEF = 7;
  localparam int DW_DEF = 32;

  typedef enum logic [1:0] {ARB, LOCK0, LOCK1} arb_state_t;

  typedef logic port_t;

endpackage

// File: rtl/dm_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker: on a tie the port that did not win last time is granted.
module rr_pick2
  import dm_arb_pkg::*;
(
  input  logic [1:0] req,
  input  port_t      last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/dm_arbiter.sv
// Two-port arbiter/sequencer for the single-ported data memory, with round-robin
// fairness, a per-port lock for atomic read-modify-write and a one-cycle read return.
module dm_arbiter
  import dm_arb_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           req,
  input  logic [1:0]           we,
  input  logic [1:0]           lock,
  input  logic [1:0][AW-1:0]   p_addr,
  input  logic [1:0][DW-1:0]   p_wdata,
  output logic [1:0]           gnt,
  output logic [1:0]           rvalid,
  output logic [DW-1:0]        p_rdata,
  output logic [AW-1:0]        addr,
  output logic                 rd,
  output logic                 wr,
  output logic [DW-1:0]        wdata,
  input  logic [DW-1:0]        rdata,
  output logic                 locked
);

  arb_state_t state;
  port_t      last;
  logic [1:0] req_m;
  logic [1:0] pick;
  logic       gnt_any;
  port_t      w;
  logic       vld_p1;
  port_t      rd_owner_p1;

  // A locked port hides the other requester from the picker entirely.
  always_comb begin
    case (state)
      LOCK0:   req_m = {1'b0, req[0]};
      LOCK1:   req_m = {req[1], 1'b0};
      default: req_m = req;
    endcase
  end

  rr_pick2 u_pick (
    .req  (req_m),
    .last (last),
    .gnt  (pick)
  );

  assign gnt     = rst_n ? pick : 2'b00;
  assign gnt_any = |gnt;
  assign w       = gnt[1];

  assign wr      = gnt_any & we[w];
  assign rd      = gnt_any & ~we[w];
  assign addr    = gnt_any ? p_addr[w]  : '0;
  assign wdata   = gnt_any ? p_wdata[w] : '0;
  assign locked  = (state != ARB);

  // Stage p1: read return, one cycle after the granted read.
  assign rvalid  = vld_p1 ? (rd_owner_p1 ? 2'b10 : 2'b01) : 2'b00;
  assign p_rdata = rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ARB;
      last   <= 1'b1;
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= rd;
      if (gnt_any) last <= w;
      case (state)
        ARB: begin
          if (gnt_any && lock[w]) state <= w ? LOCK1 : LOCK0;
        end
        LOCK0: begin
          if (!lock[0] && (gnt[0] || !req[0])) state <= ARB;
        end
        LOCK1: begin
          if (!lock[1] && (gnt[1] || !req[1])) state <= ARB;
        end
        default: state <= ARB;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    rd_owner_p1 <= w;
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: directed scenarios followed by a randomized run, all
// checked against a transaction-level reference of the arbiter and memory.
module tb_dm_arbiter;

  localparam int AW = 7;
  localparam int DW = 32;

  logic                clk = 1'b0;
  logic                rst_n = 1'b1;
  logic [1:0]          req, we, lock;
  logic [1:0][AW-1:0]  p_addr;
  logic [1:0][DW-1:0]  p_wdata;
  logic [1:0]          gnt, rvalid;
  logic [DW-1:0]       p_rdata, wdata, rdata;
  logic [AW-1:0]       addr;
  logic                rd, wr, locked;

  always #5 clk = ~clk;

  dm_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .we      (we),
    .lock    (lock),
    .p_addr  (p_addr),
    .p_wdata (p_wdata),
    .gnt     (gnt),
    .rvalid  (rvalid),
    .p_rdata (p_rdata),
    .addr    (addr),
    .rd      (rd),
    .wr      (wr),
    .wdata   (wdata),
    .rdata   (rdata),
    .locked  (locked)
  );

  // Single-ported memory standing in for dm.
  logic [DW-1:0] dm_mem [128];
  always @(posedge clk) begin
    if (wr) dm_mem[addr] <= wdata;
    if (rd) rdata <= dm_mem[addr];
  end

  // Reference: expected memory image, lock owner (-1 = none), last winner, pending read.
  logic [DW-1:0] ref_mem [128];
  int            owner, last_m, pend_port;
  logic [DW-1:0] pend_data;
  logic [1:0]    exp_gnt, obs_gnt;
  int            errors = 0;
  int            checks = 0;

  int            q0[$];
  int            q1[$];
  logic [1:0]    order[$];
  logic [1:0]    exp_order [6] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
  int            rb_addr [6] = '{5, 10, 15, 20, 25, 30};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    owner     = -1;
    last_m    = 1;
    pend_port = -1;
  endtask

  function automatic logic [1:0] model_gnt();
    logic [1:0] elig;
    if (!rst_n) return 2'b00;
    elig = (owner < 0) ? req : (req & (2'b01 << owner));
    if (elig == 2'b11) return (last_m == 0) ? 2'b10 : 2'b01;
    return elig;
  endfunction

  task automatic set_port(input int p, input logic r, input logic wen, input logic l,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[p]     = r;
    we[p]      = wen;
    lock[p]    = l;
    p_addr[p]  = a;
    p_wdata[p] = d;
  endtask

  // Check combinational outputs mid-cycle, then advance the reference at the edge.
  task automatic run_cycle();
    int         w;
    logic [1:0] rv_exp;
    logic       any;
    @(negedge clk);
    exp_gnt = model_gnt();
    obs_gnt = gnt;
    any     = (exp_gnt != 2'b00);
    w       = exp_gnt[1] ? 1 : 0;
    chk("gnt", 64'(gnt), 64'(exp_gnt));
    chk("wr", 64'(wr), 64'(any && we[w]));
    chk("rd", 64'(rd), 64'(any && !we[w]));
    chk("addr", 64'(addr), any ? 64'(p_addr[w]) : 64'd0);
    chk("wdata", 64'(wdata), any ? 64'(p_wdata[w]) : 64'd0);
    chk("locked", 64'(locked), 64'(rst_n && owner >= 0));
    rv_exp = (pend_port < 0) ? 2'b00 : (2'b01 << pend_port);
    chk("rvalid", 64'(rvalid), 64'(rv_exp));
    if (pend_port >= 0) chk("p_rdata", 64'(p_rdata), 64'(pend_data));
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      pend_port = -1;
      if (any) begin
        last_m = w;
        if (we[w]) ref_mem[p_addr[w]] = p_wdata[w];
        else begin
          pend_port = w;
          pend_data = ref_mem[p_addr[w]];
        end
        if (owner < 0 && lock[w]) owner = w;
        else if (owner == w && !lock[w]) owner = -1;
      end else if (owner >= 0 && !req[owner] && !lock[owner]) begin
        owner = -1;
      end
    end
    #1;
  endtask

  task automatic rand_txn(input int p);
    set_port(p, 1'b1, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
             AW'($urandom_range(0, 127)), DW'($urandom()));
  endtask

  initial begin
    int guard;
    for (int i = 0; i < 128; i++) begin
      dm_mem[i]  = 32'h5A00_0000 + DW'(i);
      ref_mem[i] = 32'h5A00_0000 + DW'(i);
    end
    req = '0; we = '0; lock = '0; p_addr = '0; p_wdata = '0;
    model_reset();

    // Reset held with both ports requesting.
    #2 rst_n = 1'b0;
    req = 2'b11;
    run_cycle();
    run_cycle();
    req = 2'b00;
    rst_n = 1'b1;

    // Solo write then read on port 0.
    set_port(0, 1, 1, 0, 7'd5, 32'd10);
    run_cycle();
    chk("s2_wr_gnt", 64'(obs_gnt), 64'(2'b01));
    set_port(0, 1, 0, 0, 7'd5, 32'd0);
    run_cycle();
    set_port(0, 0, 0, 0, 7'd0, 32'd0);
    chk("s2_rvalid", 64'(rvalid), 64'(2'b01));
    chk("s2_rdata", 64'(p_rdata), 64'd10);
    run_cycle();

    // Port 1 solo write so the next tie goes to port 0.
    set_port(1, 1, 1, 0, 7'd40, 32'd99);
    run_cycle();
    set_port(1, 0, 0, 0, 7'd0, 32'd0);

    // Fairness: both ports stream writes.
    q0 = '{5, 10, 15};
    q1 = '{20, 25, 30};
    guard = 0;
    while ((q0.size() != 0 || q1.size() != 0) && guard < 20) begin
      if (q0.size() != 0) set_port(0, 1, 1, 0, AW'(q0[0]), DW'(q0[0] * 2));
      else                set_port(0, 0, 0, 0, 7'd0, 32'd0);
      if (q1.size() != 0) set_port(1, 1, 1, 0, AW'(q1[0]), DW'(q1[0] * 2));
      else                set_port(1, 0, 0, 0, 7'd0, 32'd0);
      run_cycle();
      order.push_back(obs_gnt);
      if (exp_gnt[0]) void'(q0.pop_front());
      if (exp_gnt[1]) void'(q1.pop_front());
      guard++;
    end
    set_port(0, 0, 0, 0, 7'd0, 32'd0);
    set_port(1, 0, 0, 0, 7'd0, 32'd0);
    chk("s3_len", 64'(order.size()), 64'd6);
    for (int k = 0; k < 6 && k < order.size(); k++) chk("s3_order", 64'(order[k]), 64'(exp_order[k]));
    foreach (rb_addr[k]) begin
      set_port(0, 1, 0, 0, AW'(rb_addr[k]), 32'd0);
      run_cycle();
    end
    set_port(0, 0, 0, 0, 7'd0, 32'd0);
    run_cycle();

    // Locked read-modify-write by port 1 while port 0 waits.
    set_port(0, 1, 1, 0, 7'd50, 32'h77);
    set_port(1, 1, 0, 1, 7'd100, 32'd0);
    run_cycle();
    chk("s4_rd_gnt", 64'(obs_gnt), 64'(2'b10));
    chk("s4_locked", 64'(locked), 64'd1);
    set_port(1, 1, 1, 0, 7'd100, ref_mem[100] + 32'd1);
    run_cycle();
    chk("s4_wr_gnt", 64'(obs_gnt), 64'(2'b10));
    chk("s4_unlocked", 64'(locked), 64'd0);
    set_port(1, 0, 0, 0, 7'd0, 32'd0);
    run_cycle();
    chk("s4_p0_gnt", 64'(obs_gnt), 64'(2'b01));
    set_port(0, 1, 0, 0, 7'd100, 32'd0);
    run_cycle();
    set_port(0, 0, 0, 0, 7'd0, 32'd0);
    chk("s4_rmw", 64'(p_rdata), 64'h5A00_0065);
    run_cycle();

    // Reset while port 0 holds the lock with a read outstanding.
    set_port(0, 1, 0, 1, 7'd5, 32'd0);
    run_cycle();
    chk("s5_locked", 64'(locked), 64'd1);
    set_port(0, 0, 0, 0, 7'd0, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("s5_rvalid_drop", 64'(rvalid), 64'd0);
    chk("s5_unlocked", 64'(locked), 64'd0);
    model_reset();
    run_cycle();
    rst_n = 1'b1;
    run_cycle();
    run_cycle();

    // Back-to-back reads from port 0 then port 1.
    set_port(0, 1, 0, 0, 7'd5, 32'd0);
    run_cycle();
    set_port(0, 0, 0, 0, 7'd0, 32'd0);
    set_port(1, 1, 0, 0, 7'd20, 32'd0);
    chk("s6_rvalid0", 64'(rvalid), 64'(2'b01));
    chk("s6_rdata0", 64'(p_rdata), 64'd10);
    run_cycle();
    set_port(1, 0, 0, 0, 7'd0, 32'd0);
    chk("s6_rvalid1", 64'(rvalid), 64'(2'b10));
    chk("s6_rdata1", 64'(p_rdata), 64'd40);
    run_cycle();

    // Randomized traffic; a port keeps its request stable until granted.
    for (int n = 0; n < 400; n++) begin
      for (int p = 0; p < 2; p++)
        if (!req[p] && $urandom_range(0, 2) != 0) rand_txn(p);
      run_cycle();
      for (int p = 0; p < 2; p++) begin
        if (exp_gnt[p]) begin
          if ($urandom_range(0, 1) == 1) rand_txn(p);
          else set_port(p, 0, 0, 0, 7'd0, 32'd0);
        end
      end
    end
    set_port(0, 0, 0, 0, 7'd0, 32'd0);
    set_port(1, 0, 0, 0, 7'd0, 32'd0);
    run_cycle();
    run_cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
